// File: rtl/ysyx_23060180_mem_pkg.sv
// Shared types and helpers for the memory responder: default constants,
// the response record and the address decode functions.
package ysyx_23060180_mem_pkg;

  localparam logic [31:0] DEF_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] DEF_ERR_DATA  = 32'hDEAD_BEEF;

  // One read response as it travels down the delay line.
  typedef struct packed {
    logic [31:0] data;
    logic        valid;
    logic        err;
  } rsp_t;

  // Range test done in 33 bits so addresses below base never wrap into range
  // and base + 4*depth never overflows past 2^32.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input int unsigned depth);
    logic [32:0] a;
    logic [32:0] lo;
    logic [32:0] hi;
    a  = {1'b0, addr};
    lo = {1'b0, base};
    hi = lo + (33'(depth) << 2);
    return (a >= lo) && (a < hi);
  endfunction

  // Word index relative to base; byte-offset bits [1:0] are dropped.
  function automatic logic [31:0] word_idx(input logic [31:0] addr,
                                           input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    return {2'b00, off[31:2]};
  endfunction

endpackage

// File: rtl/ysyx_23060180_rd_pipe.sv
// Delay line for read responses. DEPTH registers of rsp_t; DEPTH=0 is a
// straight pass-through. Data is only loaded alongside a valid response so
// the last stage holds the most recent read data between responses.
module ysyx_23060180_rd_pipe
  import ysyx_23060180_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 0
) (
  input  logic clk,
  input  logic rst,
  input  rsp_t i_rsp,
  output rsp_t o_rsp
);

  if (DEPTH == 0) begin : g_pass
    logic w_unused;
    assign w_unused = &{1'b0, clk, rst};
    assign o_rsp    = i_rsp;
  end else begin : g_pipe
    rsp_t r_stage [DEPTH];
    rsp_t w_src   [DEPTH];

    assign w_src[0] = i_rsp;
    for (genvar i = 1; i < DEPTH; i++) begin : g_link
      assign w_src[i] = r_stage[i-1];
    end

    // Shift responses one stage per clock; reset drops everything in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          r_stage[i].valid <= w_src[i].valid;
          r_stage[i].err   <= w_src[i].err;
          if (w_src[i].valid) r_stage[i].data <= w_src[i].data;
        end
      end
    end

    assign o_rsp = r_stage[DEPTH-1];
  end

endmodule

// File: rtl/ysyx_23060180_mem_resp.sv
// Memory responder: word-organised RAM with a byte-masked write port and a
// pipelined read port. Stage 0 reads the array with write-first merging;
// the remaining LATENCY-1 stages live in ysyx_23060180_rd_pipe.
module ysyx_23060180_mem_resp
  import ysyx_23060180_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] ERR_DATA    = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic [31:0] mem_raddr,
  output logic [31:0] mem_rdata,
  output logic        mem_rvalid,
  output logic        mem_rerr,
  input  logic        mem_wr,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wmask,
  output logic        mem_werr
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

  logic [31:0]      r_mem [DEPTH_WORDS];
  rsp_t             r_stage0;
  logic             r_werr;
  rsp_t             w_rsp;

  logic             w_rd_in;
  logic             w_wr_in;
  logic             w_wr_ok;
  logic [IDX_W-1:0] w_ridx;
  logic [IDX_W-1:0] w_widx;
  logic [31:0]      w_merged;

  assign w_rd_in = in_range(mem_raddr, BASE_ADDR, DEPTH_WORDS);
  assign w_wr_in = in_range(mem_waddr, BASE_ADDR, DEPTH_WORDS);
  assign w_ridx  = IDX_W'(word_idx(mem_raddr, BASE_ADDR));
  assign w_widx  = IDX_W'(word_idx(mem_waddr, BASE_ADDR));
  // A write sampled while rst is high is dropped.
  assign w_wr_ok = mem_wr && w_wr_in && !rst;

  // Read word with this edge's write bytes folded in (write-first).
  always_comb begin
    // NOTE: default first so every path assigns w_merged and no latch is inferred.
    w_merged = r_mem[w_ridx];
    if (w_wr_ok && (w_widx == w_ridx)) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) w_merged[8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
  end

  // Byte-masked array write.
  // NOTE: the array has no reset; contents are undefined until written or preloaded.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) r_mem[w_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Stage-0 response register and the dropped-write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage0 <= '0;
      r_werr   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values in parallel.
      r_stage0.valid <= mem_rd;
      r_stage0.err   <= mem_rd && !w_rd_in;
      if (mem_rd) r_stage0.data <= w_rd_in ? w_merged : ERR_DATA;
      r_werr <= mem_wr && !w_wr_in;
    end
  end

  ysyx_23060180_rd_pipe #(
    .DEPTH (LATENCY - 1)
  ) u_rd_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_rsp (r_stage0),
    .o_rsp (w_rsp)
  );

  assign mem_rdata  = w_rsp.data;
  assign mem_rvalid = w_rsp.valid;
  assign mem_rerr   = w_rsp.err;
  assign mem_werr   = r_werr;

endmodule

// File: tb/tb_ysyx_23060180_mem_resp.sv
// Self-checking bench for ysyx_23060180_mem_resp: a LATENCY=1 and a LATENCY=3
// instance share one stimulus stream and are compared against a word-array
// model with a response queue.
module tb_ysyx_23060180_mem_resp;

  localparam logic [31:0] B   = 32'h8000_0000;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd = 1'b0;
  logic [31:0] mem_raddr = '0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_waddr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wmask = '0;

  logic [31:0] rdata1, rdata3;
  logic        rvalid1, rvalid3, rerr1, rerr3, werr1, werr3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_23060180_mem_resp #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
    .mem_rdata(rdata1), .mem_rvalid(rvalid1), .mem_rerr(rerr1),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_werr(werr1)
  );

  ysyx_23060180_mem_resp #(.LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_raddr(mem_raddr),
    .mem_rdata(rdata3), .mem_rvalid(rvalid3), .mem_rerr(rerr3),
    .mem_wr(mem_wr), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_werr(werr3)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] d;
    logic        v;
    logic        e;
  } ersp_t;

  logic [31:0] model [int];
  ersp_t       q3 [$];
  logic [31:0] e_rdata, e3_rdata;
  logic        e_rvalid, e_rerr, e_werr, e3_rvalid, e3_rerr;

  function automatic bit addr_ok(input logic [31:0] a);
    longint unsigned x;
    x = longint'(a);
    return (x >= 64'h8000_0000) && (x < 64'h8000_0000 + 4 * 4096);
  endfunction

  function automatic int key_of(input logic [31:0] a);
    return int'((longint'(a) - 64'h8000_0000) / 4);
  endfunction

  task automatic model_reset();
    e_rdata = '0; e_rvalid = 1'b0; e_rerr = 1'b0; e_werr = 1'b0;
    e3_rdata = '0; e3_rvalid = 1'b0; e3_rerr = 1'b0;
    q3.delete();
  endtask

  // Apply the write, then read: the updated word is exactly the write-first result.
  task automatic model_edge();
    logic [31:0] w;
    ersp_t fresh, out;
    e_werr = mem_wr && !addr_ok(mem_waddr);
    if (mem_wr && addr_ok(mem_waddr)) begin
      w = model.exists(key_of(mem_waddr)) ? model[key_of(mem_waddr)] : 32'h0;
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      model[key_of(mem_waddr)] = w;
    end
    fresh.v = mem_rd;
    fresh.e = mem_rd && !addr_ok(mem_raddr);
    fresh.d = (mem_rd && addr_ok(mem_raddr)) ? model[key_of(mem_raddr)] : ERR;
    e_rvalid = fresh.v;
    e_rerr   = fresh.e;
    if (fresh.v) e_rdata = fresh.d;
    // LATENCY=3: the response appears two edges after the stage-0 one.
    q3.push_back(fresh);
    out = '0;
    if (q3.size() > 2) out = q3.pop_front();
    e3_rvalid = out.v;
    e3_rerr   = out.e;
    if (out.v) e3_rdata = out.d;
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic [31:0] raddr, input logic wr,
                       input logic [31:0] waddr, input logic [31:0] wdata,
                       input logic [3:0] wmask);
    mem_rd = rd; mem_raddr = raddr; mem_wr = wr;
    mem_waddr = waddr; mem_wdata = wdata; mem_wmask = wmask;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, '0, 4'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with full model comparison of both instances.
  task automatic cycle(input string tag);
    model_edge();
    tick();
    check({tag, " rvalid1"}, rvalid1, e_rvalid);
    check({tag, " rerr1"},   rerr1,   e_rerr);
    check({tag, " rdata1"},  rdata1,  e_rdata);
    check({tag, " werr1"},   werr1,   e_werr);
    check({tag, " rvalid3"}, rvalid3, e3_rvalid);
    check({tag, " rerr3"},   rerr3,   e3_rerr);
    check({tag, " rdata3"},  rdata3,  e3_rdata);
    check({tag, " werr3"},   werr3,   e_werr);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rd;
    logic [31:0] raddr;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
    logic        ew;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic [31:0] raddr, input logic wr,
                              input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic [3:0] wmask, input logic ev, input logic ee,
                              input logic [31:0] ed, input logic ew);
    vec_t v;
    v.rd = rd; v.raddr = raddr; v.wr = wr; v.waddr = waddr; v.wdata = wdata;
    v.wmask = wmask; v.ev = ev; v.ee = ee; v.ed = ed; v.ew = ew;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    logic [31:0] r, oor [4];

    // Reset state.
    idle();
    repeat (3) tick();
    check("reset rdata1", rdata1, 32'h0);
    check("reset rvalid1", rvalid1, 1'b0);
    check("reset rerr1", rerr1, 1'b0);
    check("reset werr1", werr1, 1'b0);
    check("reset rdata3", rdata3, 32'h0);
    check("reset rvalid3", rvalid3, 1'b0);
    rst = 1'b0;
    model_reset();

    //             rd  raddr            wr  waddr            wdata          mask   v  e  data           werr
    vecs[0]  = mk(0, 32'h0,           1, B + 32'h10,     32'h1234_5678, 4'hF, 0, 0, 32'h0,          0);
    vecs[1]  = mk(1, B + 32'h10,      1, B,              32'h0BAD_F00D, 4'hF, 1, 0, 32'h1234_5678,  0);
    vecs[2]  = mk(1, B + 32'h10,      1, B + 32'h10,     32'hAABB_CCDD, 4'h5, 1, 0, 32'h12BB_56DD,  0);
    vecs[3]  = mk(1, 32'h7FFF_FFFC,   0, 32'h0,          32'h0,         4'h0, 1, 1, ERR,            0);
    vecs[4]  = mk(1, 32'h8000_4000,   1, 32'h8000_4000,  32'hFFFF_FFFF, 4'hF, 1, 1, ERR,            1);
    vecs[5]  = mk(0, 32'h0,           0, 32'h0,          32'h0,         4'h0, 0, 0, ERR,            0);
    vecs[6]  = mk(1, B,               0, 32'h0,          32'h0,         4'h0, 1, 0, 32'h0BAD_F00D,  0);
    vecs[7]  = mk(1, B + 32'h13,      0, 32'h0,          32'h0,         4'h0, 1, 0, 32'h12BB_56DD,  0);
    vecs[8]  = mk(1, B + 32'h10,      1, B + 32'h10,     32'hFFFF_FFFF, 4'h0, 1, 0, 32'h12BB_56DD,  0);
    vecs[9]  = mk(1, B + 32'h3FFC,    1, B + 32'h3FFC,   32'h1357_9BDF, 4'hF, 1, 0, 32'h1357_9BDF,  0);
    vecs[10] = mk(0, 32'h0,           1, 32'h7FFF_FFFC,  32'h0,         4'hF, 0, 0, 32'h1357_9BDF,  1);
    vecs[11] = mk(1, 32'hFFFF_FFFC,   1, 32'hFFFF_FFFC,  32'h0,         4'hF, 1, 1, ERR,            1);
    vecs[12] = mk(1, B + 32'h3FFC,    0, 32'h0,          32'h0,         4'h0, 1, 0, 32'h1357_9BDF,  0);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rd, vecs[i].raddr, vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].wmask);
      model_edge();
      tick();
      check($sformatf("vec%0d rvalid", i), rvalid1, vecs[i].ev);
      check($sformatf("vec%0d rerr", i),   rerr1,   vecs[i].ee);
      check($sformatf("vec%0d rdata", i),  rdata1,  vecs[i].ed);
      check($sformatf("vec%0d werr", i),   werr1,   vecs[i].ew);
    end

    // Back-to-back burst: preload word k with k, then read 8 cycles straight.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, '0, 1'b1, B + 32'(4 * k), 32'(k), 4'hF);
      cycle("preload");
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, B + 32'(4 * k), 1'b0, '0, '0, 4'h0);
      cycle("burst");
      check($sformatf("burst%0d data", k), rdata1, 32'(k));
      check($sformatf("burst%0d valid", k), rvalid1, 1'b1);
    end
    for (int k = 8; k < 16; k++) begin
      drive(1'b0, '0, 1'b1, B + 32'(4 * k), $urandom, 4'hF);
      cycle("init");
    end
    idle();
    repeat (3) cycle("drain");

    // LATENCY=3: two reads in flight, then reset kills them.
    drive(1'b1, B, 1'b0, '0, '0, 4'h0);
    tick();
    drive(1'b1, B + 32'h4, 1'b0, '0, '0, 4'h0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    check("flight rvalid3 at rst", rvalid3, 1'b0);
    check("flight rdata3 at rst", rdata3, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("flight rvalid3 in rst %0d", c), rvalid3, 1'b0);
      check($sformatf("flight rerr3 in rst %0d", c), rerr3, 1'b0);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check($sformatf("flight rvalid3 after rst %0d", c), rvalid3, 1'b0);
      check($sformatf("flight rdata3 after rst %0d", c), rdata3, 32'h0);
    end
    drive(1'b1, B + 32'h4, 1'b0, '0, '0, 4'h0);
    tick();
    idle();
    check("lat3 edge0 rvalid", rvalid3, 1'b0);
    tick();
    check("lat3 edge1 rvalid", rvalid3, 1'b0);
    tick();
    check("lat3 edge2 rvalid", rvalid3, 1'b1);
    check("lat3 edge2 rdata", rdata3, 32'h1);
    tick();
    check("lat3 edge3 rvalid", rvalid3, 1'b0);
    check("lat3 edge3 rdata hold", rdata3, 32'h1);

    // Re-align both instances with the model, then random traffic.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    oor[0] = 32'h7FFF_FFFC; oor[1] = 32'h8000_4000;
    oor[2] = 32'h0000_0010; oor[3] = 32'hFFFF_FFF0;
    for (int n = 0; n < 300; n++) begin
      logic [31:0] ra, wa;
      r  = $urandom_range(0, 7);
      ra = (r < 6) ? B + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3))
         : (r == 6) ? B + 32'h3FFC : oor[$urandom_range(0, 3)];
      r  = $urandom_range(0, 7);
      wa = (r < 6) ? B + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3))
         : (r == 6) ? B + 32'h3FFC : oor[$urandom_range(0, 3)];
      drive(($urandom_range(0, 3) != 0), ra, ($urandom_range(0, 2) == 0), wa,
            $urandom, 4'($urandom_range(0, 15)));
      cycle("rand");
    end
    idle();
    repeat (4) cycle("tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
